// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared state encoding and default constants for the audio receive path
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    REPORT
  } tone_state_t;

  localparam int unsigned DEF_CLK_HZ         = 27000000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1350000;
  localparam int unsigned DEF_FILT           = 4;

endpackage

// File: rtl/sig_filter.sv
// rtl/sig_filter.sv - input synchronizer, glitch filter and registered rising-edge pulse
module sig_filter
  import audio_pkg::*;
#(
  parameter int unsigned FILT = DEF_FILT
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic rise
);

  localparam int unsigned RUN_W = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT - 1);

  logic             sync1;
  logic             sync2;
  logic             lvl;
  logic             lvl_d;
  logic [RUN_W-1:0] run;

  // lvl only follows sync2 once the disagreement has lasted FILT cycles in a row
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      run   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      lvl_d <= lvl;
      rise  <= lvl & ~lvl_d;
      if (sync2 != lvl) begin
        if (run == RUN_LAST) begin
          lvl <= sync2;
          run <= '0;
        end else begin
          run <= run + 1'b1;
        end
      end else begin
        run <= '0;
      end
    end
  end

endmodule

// File: rtl/tone_detector.sv
// rtl/tone_detector.sv - measures and averages the period of a 1-bit square wave, flags silence
module tone_detector
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned PERIOD_W       = 24,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned FILT           = DEF_FILT,
  parameter int unsigned AVG_LOG2       = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                audio_in,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                tone_present,
  output logic                overflow
);

  localparam int unsigned ACC_W = PERIOD_W + AVG_LOG2;
  localparam int unsigned NS_W  = AVG_LOG2 + 1;
  localparam logic [NS_W-1:0]     NS_FULL = NS_W'(1 << AVG_LOG2);
  localparam logic [PERIOD_W-1:0] TMO     = PERIOD_W'(TIMEOUT_CYCLES);

  if (CLK_HZ == 0 || FILT < 1 || 64'(TIMEOUT_CYCLES) >= (64'd1 << PERIOD_W)) begin : g_bad_cfg
    $error("tone_detector: invalid parameter set");
  end

  tone_state_t         state;
  logic [PERIOD_W-1:0] cnt;
  logic [ACC_W-1:0]    acc;
  logic [NS_W-1:0]     nsamp;
  logic                rise;

  logic [ACC_W-1:0]    acc_sum;
  logic [NS_W-1:0]     ns_next;

  sig_filter #(.FILT(FILT)) u_filt (
    .clk   (clk),
    .resetn(resetn),
    .din   (audio_in),
    .rise  (rise)
  );

  // REPORT empties the accumulator in the same cycle, so a coincident rise starts a fresh batch
  always_comb begin
    acc_sum = ((state == REPORT) ? '0 : acc) + ACC_W'(cnt);
    ns_next = ((state == REPORT) ? '0 : nsamp) + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      nsamp        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      tone_present <= 1'b0;
      overflow     <= 1'b0;
    end else if (!enable) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      nsamp        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      tone_present <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt   <= '0;
          acc   <= '0;
          nsamp <= '0;
          if (rise) begin
            cnt   <= PERIOD_W'(1);
            state <= MEASURE;
          end
        end
        MEASURE, REPORT: begin
          if (state == REPORT) begin
            period       <= PERIOD_W'(acc >> AVG_LOG2);
            period_valid <= 1'b1;
            tone_present <= 1'b1;
            acc          <= '0;
            nsamp        <= '0;
          end
          // a rise landing on the timeout cycle still counts as a sample
          if (rise) begin
            acc   <= acc_sum;
            nsamp <= ns_next;
            cnt   <= PERIOD_W'(1);
            state <= (ns_next == NS_FULL) ? REPORT : MEASURE;
          end else if (cnt == TMO) begin
            state        <= IDLE;
            tone_present <= 1'b0;
            period       <= '0;
            if (tone_present) overflow <= 1'b1;
          end else begin
            if (!(&cnt)) cnt <= cnt + 1'b1;
            state <= MEASURE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_detector.sv
// tb/tb_tone_detector.sv - randomized self-checking bench for tone_detector
module tb_tone_detector;

  localparam int PW   = 16;
  localparam int TMO  = 1000;
  localparam int FILT = 2;
  localparam int AVG  = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          audio_in = 1'b0;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          tone_present;
  logic          overflow;

  tone_detector #(
    .CLK_HZ(27000000), .PERIOD_W(PW), .TIMEOUT_CYCLES(TMO), .FILT(FILT), .AVG_LOG2(AVG)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .audio_in(audio_in),
    .period(period), .period_valid(period_valid), .tone_present(tone_present), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  int   got_q[$];
  int   got_t[$];
  int   dbl_cnt = 0;
  logic prev_v = 1'b0;

  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      got_q.push_back(int'(period));
      got_t.push_back(cyc);
      if (prev_v === 1'b1) dbl_cnt++;
    end
    prev_v = period_valid;
  end

  // reference: work purely on the gaps between driven rising edges
  int rise_q[$];
  int exp_rep[$];
  int m_per;
  bit m_tp;
  bit m_ovf;

  function automatic void run_model(input int t_end);
    bit act = 0;
    int st = 0, n = 0, sum = 0;
    exp_rep.delete();
    m_tp = 0; m_per = 0; m_ovf = 0;
    foreach (rise_q[i]) begin
      if (act && rise_q[i] - st > TMO) begin
        if (m_tp) m_ovf = 1;
        m_tp = 0; m_per = 0; act = 0;
      end
      if (!act) begin
        act = 1; st = rise_q[i]; n = 0; sum = 0;
      end else begin
        sum += rise_q[i] - st;
        st = rise_q[i];
        n++;
        if (n == (1 << AVG)) begin
          m_per = sum / (1 << AVG);
          exp_rep.push_back(m_per);
          m_tp = 1; n = 0; sum = 0;
        end
      end
    end
    if (act && t_end - st > TMO) begin
      if (m_tp) m_ovf = 1;
      m_tp = 0; m_per = 0;
    end
  endfunction

  function automatic int rep_mismatch();
    int bad = int'(got_q.size() != exp_rep.size());
    foreach (exp_rep[i]) if (i < got_q.size() && got_q[i] != exp_rep[i]) bad++;
    return bad;
  endfunction

  task automatic new_session();
    @(negedge clk);
    enable = 1'b0; audio_in = 1'b0;
    repeat (12) @(negedge clk);
    enable = 1'b1;
    rise_q.delete(); got_q.delete(); got_t.delete(); dbl_cnt = 0;
    @(negedge clk);
  endtask

  // one period of `per` cycles starting with a rise; optional pulse of width gw in the low phase
  task automatic wave(input int per, input int gw);
    int gs = per / 2 + per / 4;
    for (int i = 0; i < per; i++) begin
      @(negedge clk);
      if (i == 0) rise_q.push_back(cyc);
      if (gw > 0 && i >= gs && i < gs + gw) audio_in = 1'b1;
      else audio_in = (i < per / 2);
      if (gw >= FILT && i == gs) rise_q.push_back(cyc);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; enable = 1'b1; audio_in = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({period, period_valid, tone_present, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got period=%0d valid=%b tp=%b ovf=%b, need all 0",
               period, period_valid, tone_present, overflow);
    end
    resetn = 1'b1;
    got_q.delete();
    repeat (2000) @(negedge clk);
    n_chk++;
    if (got_q.size() != 0) begin
      n_fail++; $display("FAIL idle_strobes got %0d strobes, need 0", got_q.size());
    end
    n_chk++;
    if (tone_present !== 1'b0 || period !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_state got tp=%b period=%0d ovf=%b, need 0/0/0", tone_present, period, overflow);
    end
  endtask

  task automatic check_session(input string name);
    run_model(cyc);
    n_chk++;
    if (rep_mismatch() != 0) begin
      n_fail++;
      $display("FAIL %s_reports got %0d reports (first %0d), need %0d (first %0d)", name,
               got_q.size(), (got_q.size() > 0) ? got_q[0] : -1,
               exp_rep.size(), (exp_rep.size() > 0) ? exp_rep[0] : -1);
    end
    n_chk++;
    if (tone_present !== m_tp || int'(period) != m_per || overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL %s_state got tp=%b period=%0d ovf=%b, need tp=%b period=%0d ovf=%b", name,
               tone_present, period, overflow, m_tp, m_per, m_ovf);
    end
    n_chk++;
    if (dbl_cnt != 0) begin
      n_fail++; $display("FAIL %s_double_strobe got %0d back-to-back strobes, need 0", name, dbl_cnt);
    end
  endtask

  task automatic test_steady();
    int bad = 0;
    new_session();
    repeat (13) wave(200, 0);
    repeat (50) @(negedge clk);
    check_session("steady");
    n_chk++;
    if (got_q.size() == 0 || got_q[0] != 200) begin
      n_fail++; $display("FAIL steady_value got %0d, need 200", (got_q.size() > 0) ? got_q[0] : -1);
    end
    for (int i = 1; i < got_t.size(); i++) if (got_t[i] - got_t[i-1] != 4 * 200) bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++; $display("FAIL steady_interval got %0d wrong strobe spacings, need 0 (800 cycles)", bad);
    end
  endtask

  task automatic test_average();
    int pers[9] = '{100, 101, 101, 101, 150, 150, 150, 150, 150};
    new_session();
    foreach (pers[i]) wave(pers[i], 0);
    repeat (50) @(negedge clk);
    check_session("average");
  endtask

  task automatic test_random();
    new_session();
    repeat (12) wave(int'($urandom_range(24, 900)), 0);
    wave(60, 0);
    repeat (20) @(negedge clk);
    check_session("random");
  endtask

  task automatic test_glitch();
    new_session();
    repeat (9) wave(200, 1);
    repeat (50) @(negedge clk);
    check_session("glitch1");
    new_session();
    repeat (9) wave(200, 3);
    repeat (50) @(negedge clk);
    check_session("glitch3");
    n_chk++;
    if (got_q.size() == 0 || got_q[0] == 200) begin
      n_fail++; $display("FAIL glitch3_changed got %0d, need a period other than 200",
                         (got_q.size() > 0) ? got_q[0] : -1);
    end
  endtask

  task automatic test_timeout();
    int last;
    new_session();
    repeat (6) wave(200, 0);
    last = rise_q[rise_q.size() - 1];
    while (cyc < last + TMO) @(negedge clk);
    n_chk++;
    if (tone_present !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early got tp=%b at %0d cycles after last rise, need 1", tone_present, TMO);
    end
    while (cyc < last + TMO + 12) @(negedge clk);
    check_session("timeout");
    repeat (6) wave(200, 0);
    repeat (20) @(negedge clk);
    check_session("restart");
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    n_chk++;
    if (overflow !== 1'b0 || tone_present !== 1'b0 || period !== '0) begin
      n_fail++;
      $display("FAIL enable_clear got ovf=%b tp=%b period=%0d, need 0/0/0", overflow, tone_present, period);
    end
    enable = 1'b1;
  endtask

  task automatic test_boundary();
    new_session();
    repeat (5) wave(TMO, 0);
    wave(100, 0);
    repeat (20) @(negedge clk);
    check_session("gap1000");
    new_session();
    repeat (6) wave(TMO + 1, 0);
    wave(100, 0);
    repeat (20) @(negedge clk);
    check_session("gap1001");
  endtask

  task automatic test_reset_mid();
    new_session();
    repeat (7) wave(200, 0);
    @(negedge clk); #2 resetn = 1'b0;
    #1;
    n_chk++;
    if (tone_present !== 1'b0 || period !== '0 || period_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got tp=%b period=%0d valid=%b, need 0/0/0", tone_present, period, period_valid);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) wave(200, 0);
    repeat (50) @(negedge clk);
    n_chk++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL reset_discard got %0d strobes, need 1", got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_average();
    test_random();
    test_glitch();
    test_timeout();
    test_boundary();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog simulation time limit reached, need completion");
    $fatal(1);
  end

endmodule
